// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs high/low byte pairs into 16-bit words for the ram1 write port
module byte_packer #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  PAD    = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        b_in,
    input  logic              b_valid,
    input  logic              flush,
    input  logic              addr_clr,
    input  logic              mem_ack,
    output logic              b_rdy,
    output logic              hi_pending,
    output logic [15:0]       w_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic              we
);

    typedef enum logic [1:0] {HI, LO, WR} state_t;

    state_t            state, state_nx;
    logic [7:0]        hi_q, hi_nx;
    logic [15:0]       data_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              we_nx, rdy_nx, pend_nx;
    logic              clr_q, clr_nx;

    always_comb begin
        state_nx = state;
        hi_nx    = hi_q;
        data_nx  = w_data;
        addr_nx  = w_addr;
        we_nx    = we;
        rdy_nx   = b_rdy;
        pend_nx  = hi_pending;
        clr_nx   = clr_q;

        case (state)
            HI: begin
                if (addr_clr)
                    addr_nx = '0;
                if (b_valid) begin
                    hi_nx    = b_in;
                    pend_nx  = 1'b1;
                    state_nx = LO;
                end
            end
            LO: begin
                if (addr_clr)
                    addr_nx = '0;
                // a real byte takes priority over a simultaneous flush
                if (b_valid || flush) begin
                    data_nx  = {hi_q, b_valid ? b_in : PAD};
                    we_nx    = 1'b1;
                    rdy_nx   = 1'b0;
                    pend_nx  = 1'b0;
                    state_nx = WR;
                end
            end
            WR: begin
                if (mem_ack) begin
                    addr_nx  = (addr_clr || clr_q) ? '0 : w_addr + 1'b1;
                    clr_nx   = 1'b0;
                    we_nx    = 1'b0;
                    rdy_nx   = 1'b1;
                    state_nx = HI;
                end else if (addr_clr) begin
                    // address must stay stable while the write is outstanding
                    clr_nx = 1'b1;
                end
            end
            default: begin
                state_nx = HI;
                we_nx    = 1'b0;
                rdy_nx   = 1'b1;
                pend_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HI;
            hi_q       <= 8'h00;
            w_data     <= 16'h0000;
            w_addr     <= '0;
            we         <= 1'b0;
            b_rdy      <= 1'b1;
            hi_pending <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            hi_q       <= hi_nx;
            w_data     <= data_nx;
            w_addr     <= addr_nx;
            we         <= we_nx;
            b_rdy      <= rdy_nx;
            hi_pending <= pend_nx;
            clr_q      <= clr_nx;
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - scoreboard bench for byte_packer with a transaction-level reference model
module tb_byte_packer;

    localparam int         AW  = 2;
    localparam logic [7:0] PAD = 8'h00;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    b_in = 8'h00;
    logic          b_valid = 1'b0;
    logic          flush = 1'b0;
    logic          addr_clr = 1'b0;
    logic          mem_ack = 1'b0;
    logic          b_rdy;
    logic          hi_pending;
    logic [15:0]   w_data;
    logic [AW-1:0] w_addr;
    logic          we;

    always #5 clk = ~clk;

    byte_packer #(.ADDR_W(AW), .PAD(PAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .b_in       (b_in),
        .b_valid    (b_valid),
        .flush      (flush),
        .addr_clr   (addr_clr),
        .mem_ack    (mem_ack),
        .b_rdy      (b_rdy),
        .hi_pending (hi_pending),
        .w_data     (w_data),
        .w_addr     (w_addr),
        .we         (we)
    );

    int vectors = 0;
    int miscompares = 0;

    // expected writes as {data, addr}
    logic [15+AW+1:0] exp_q[$];

    bit            chk_en = 1'b0;
    bit            m_busy, m_has_hi, m_clr;
    logic [7:0]    m_hi;
    logic [15:0]   m_data;
    int            m_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a word is in flight, a high byte may be held, address counts completed writes mod 2^AW
    task automatic model_step();
        if (reset) begin
            if (m_busy && exp_q.size() > 0)
                void'(exp_q.pop_back());
            m_busy = 0; m_has_hi = 0; m_clr = 0; m_hi = 0; m_data = 0; m_addr = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
                m_addr = (m_clr || addr_clr) ? 0 : (m_addr + 1) % (1 << AW);
                m_clr  = 0;
            end else if (addr_clr) begin
                m_clr = 1;
            end
        end else begin
            if (addr_clr)
                m_addr = 0;
            if (!m_has_hi) begin
                if (b_valid) begin
                    m_has_hi = 1;
                    m_hi     = b_in;
                end
            end else if (b_valid || flush) begin
                m_data   = {m_hi, b_valid ? b_in : PAD};
                m_has_hi = 0;
                m_busy   = 1;
                exp_q.push_back({m_data, 1'b0, AW'(m_addr)});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic bv, input logic [7:0] b, input logic fl,
                         input logic ac, input logic ak);
        b_valid  = bv;
        b_in     = b;
        flush    = fl;
        addr_clr = ac;
        mem_ack  = ak;
        tick();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("b_rdy", 32'(b_rdy), 32'(!m_busy));
            check("hi_pending", 32'(hi_pending), 32'(m_has_hi));
            check("we", 32'(we), 32'(m_busy));
            check("w_data", 32'(w_data), 32'(m_data));
            check("w_addr", 32'(w_addr), 32'(m_addr));
            if (we && mem_ack && !reset) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(w_data), 32'hFFFF_FFFF);
                end else begin
                    logic [15+AW+1:0] e;
                    e = exp_q.pop_front();
                    check("wr_data", 32'(w_data), 32'(e[15+AW+1:AW+1]));
                    check("wr_addr", 32'(w_addr), 32'(e[AW-1:0]));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // basic pack, ack tied high
        drive(1, 8'hAB, 0, 0, 1);
        drive(1, 8'hCD, 0, 0, 1);
        repeat (3) drive(0, 8'h00, 0, 0, 1);

        // stalled ack with ignored bytes during the stall
        drive(1, 8'h12, 0, 0, 0);
        drive(1, 8'h34, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(i[0] ? 1'b0 : 1'b1, 8'hFF, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 1);

        // flush after high byte, flush in HI, flush colliding with a byte
        drive(1, 8'h7E, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 1);
        drive(0, 8'h00, 0, 0, 1);
        drive(1, 8'h11, 0, 0, 1);
        drive(1, 8'h55, 1, 0, 1);
        drive(0, 8'h00, 0, 0, 1);

        // address wrap over five words
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'(k), 0, 0, 1);
            drive(1, 8'(8'h80 + k), 0, 0, 1);
            drive(0, 8'h00, 0, 0, 1);
        end

        // addr_clr deferred during a stalled write
        drive(1, 8'hA1, 0, 0, 0);
        drive(1, 8'hA2, 0, 0, 0);
        drive(0, 8'h00, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 1);
        drive(1, 8'hB1, 0, 0, 1);
        drive(1, 8'hB2, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 1);

        // reset with a held high byte
        drive(1, 8'h9C, 0, 0, 1);
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 0);
        reset = 1'b0;
        drive(1, 8'h01, 0, 0, 1);
        drive(1, 8'h02, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 1);

        // back-to-back with b_valid held high
        for (int i = 0; i < 30; i++) drive(1, 8'(8'h40 + i), 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        reset = 1'b0;
        repeat (6) drive(0, 8'h00, 0, 0, 1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Write-side counterpart of the RAM read path. The read path splits each 16-bit RAM word into a high byte and a low byte for display.
- This block works the other way: it collects two 8-bit bytes (high byte first, then low byte) into one 16-bit word.
- It then writes the word to the ram1 write port using a hold-until-acknowledged handshake, and steps a write address after each completed write.
- Bytes arrive from the switch/push-button front end, one strobe per byte.

Parameters:
- ADDR_W, 8, width of the write address counter. The address wraps at 2^ADDR_W.
- PAD, 8'h00, low byte used when a lone high byte is flushed.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- b_in  input  8  incoming byte.
- b_valid  input  1  b_in is valid this cycle. The byte is accepted only when b_rdy=1.
- flush  input  1  one-cycle request to write a pending high byte padded with PAD.
- addr_clr  input  1  one-cycle request to return the write address to 0.
- mem_ack  input  1  RAM has taken the word. Sampled only in state WR.
- b_rdy  output  1  block can accept a byte this cycle.
- hi_pending  output  1  a high byte is held and the block is waiting for the low byte (display indicator).
- w_data  output  16  word presented to RAM, as {high, low}.
- w_addr  output  ADDR_W  RAM write address.
- we  output  1  write enable, held until acknowledged.

Behaviour:
- Reset, taking effect on the next clock edge:
  - state=HI, b_rdy=1, hi_pending=0, we=0.
  - w_data=16'h0000, w_addr=0, internal high-byte register=0.
- Reset asserted mid-operation:
  - Any pending byte or in-flight write is discarded and we drops at that edge.
  - Reset overrides every other input.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - HI: waiting for the high byte.
    - b_valid=1 → latch b_in as the high byte, set hi_pending=1, go to LO.
    - flush is ignored in HI.
  - LO: waiting for the low byte.
    - b_valid=1 → w_data={high, b_in}, we=1, b_rdy=0, hi_pending=0, go to WR.
    - flush=1 with b_valid=0 → w_data={high, PAD}, we=1, b_rdy=0, hi_pending=0, go to WR.
    - flush and b_valid in the same cycle → the byte wins and flush is dropped.
  - WR: we held at 1, w_data stable, b_rdy=0.
    - b_valid is ignored; the byte is lost and the source must respect b_rdy.
    - On the edge where mem_ack=1: we=0, b_rdy=1, w_addr increments, go to HI.
- Latency and throughput:
  - The low byte accepted at edge N gives we=1 from edge N onward, visible in cycle N+1.
  - With mem_ack tied high, we is high for exactly one cycle.
  - Minimum 3 cycles per word: HI→LO→WR→HI.
- Address:
  - Increments by 1 modulo 2^ADDR_W. All-ones wraps to 0 with no flag.
  - The address changes only on a completed write or on addr_clr.
- addr_clr:
  - In HI or LO: w_addr=0 at the next edge. A held high byte is kept.
  - In WR without ack: deferred. It is latched and applied when the ack arrives, giving w_addr=0 rather than incrementing.
  - In WR on the ack edge: w_addr=0.
- mem_ack outside WR is ignored.
- There is no timeout: WR waits indefinitely for mem_ack.

Test Plan:
- Basic pack: reset; bytes 8'hAB then 8'hCD, mem_ack tied 1 → we high for one cycle with w_data=16'hABCD, w_addr=0. Afterwards w_addr=1, b_rdy=1, hi_pending=0.
- Stalled ack: bytes 8'h12, 8'h34 with mem_ack held 0 for 5 cycles, plus b_valid pulses with 8'hFF during the stall → we held 5 cycles, w_data stays 16'h1234, b_rdy=0. After the ack: w_addr=1 and the 8'hFF bytes were not accepted (hi_pending=0).
- Flush: PAD=8'h00; byte 8'h7E, then flush → w_data=16'h7E00 written. Separately, flush in HI gives no write, and flush together with byte 8'h55 in LO writes {high, 8'h55}.
- Wrap and clear: ADDR_W=2; 4 words written at addresses 0,1,2,3, 5th at 0. Then addr_clr asserted during a stalled WR → the following write lands at 0, not the incremented address.
- Reset mid-op: high byte 8'h9C held, reset for one cycle → hi_pending=0, we=0, w_addr=0. Next pair 8'h01, 8'h02 gives 16'h0102.
- Back-to-back: b_valid held high with b_in incrementing each cycle, mem_ack=1 → one word every 3 cycles. Only bytes presented while b_rdy=1 appear, in order, with consecutive addresses.
